// File: rtl/lsu.sv
// rtl/lsu.sv - RV32I load/store unit: request FSM, lane steering and load extension
module lsu (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_request,
    input  logic        i_is_store,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_address,
    input  logic [31:0] i_store_data,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_fault,
    output logic [31:0] o_load_data,
    output logic        o_mem_req,
    output logic        o_mem_we,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    output logic [3:0]  o_mem_be,
    input  logic        i_mem_gnt,
    input  logic        i_mem_rvalid,
    input  logic [31:0] i_mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic [31:0] r_addr;
    logic [31:0] r_sdata;
    logic [2:0]  r_funct3;
    logic        r_is_store;

    logic        w_illegal;
    logic        w_misaligned;
    logic        w_bad;
    logic        w_accept;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [31:0] w_shifted;
    logic [31:0] w_load_ext;

    // Requests are only examined in IDLE; anything presented while busy is dropped
    assign w_accept     = (r_state == S_IDLE) && i_request;
    assign w_illegal    = (i_funct3 == 3'b011) || (i_funct3 == 3'b110) || (i_funct3 == 3'b111)
                          || (i_is_store && i_funct3[2]);
    assign w_misaligned = ((i_funct3[1:0] == 2'b01) && i_address[0])
                          || ((i_funct3[1:0] == 2'b10) && (i_address[1:0] != 2'b00));
    assign w_bad        = w_illegal || w_misaligned;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic: a store finishes on grant, a load waits for read data
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_accept && !w_bad) w_next = S_REQ;
            S_REQ:  if (i_mem_gnt) w_next = r_is_store ? S_IDLE : S_WAIT;
            S_WAIT: if (i_mem_rvalid) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Capture the operation on a legal accept; held stable for the whole access
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr     <= 32'd0;
            r_sdata    <= 32'd0;
            r_funct3   <= 3'd0;
            r_is_store <= 1'b0;
        end else if (w_accept && !w_bad) begin
            r_addr     <= i_address;
            r_sdata    <= i_store_data;
            r_funct3   <= i_funct3;
            r_is_store <= i_is_store;
        end
    end

    // Byte-lane enables and replicated write data from the captured size/offset
    always_comb begin
        w_be    = 4'b1111;
        w_wdata = r_sdata;
        case (r_funct3[1:0])
            2'b00: begin
                w_be    = 4'b0001 << r_addr[1:0];
                w_wdata = {4{r_sdata[7:0]}};
            end
            2'b01: begin
                w_be    = 4'b0011 << r_addr[1:0];
                w_wdata = {2{r_sdata[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_wdata = r_sdata;
            end
        endcase
    end

    // Memory interface is decoded from state so reset clears it without a clock
    assign o_busy      = (r_state != S_IDLE);
    assign o_mem_req   = (r_state == S_REQ);
    assign o_mem_we    = o_mem_req && r_is_store;
    assign o_mem_be    = o_mem_req ? w_be : 4'b0000;
    assign o_mem_addr  = {r_addr[31:2], 2'b00};
    assign o_mem_wdata = w_wdata;

    // Align the addressed lane to bit 0, then truncate and extend by size/sign
    assign w_shifted = i_mem_rdata >> {r_addr[1:0], 3'b000};

    always_comb begin
        w_load_ext = w_shifted;
        case (r_funct3)
            3'b000:  w_load_ext = {{24{w_shifted[7]}}, w_shifted[7:0]};
            3'b001:  w_load_ext = {{16{w_shifted[15]}}, w_shifted[15:0]};
            3'b100:  w_load_ext = {24'd0, w_shifted[7:0]};
            3'b101:  w_load_ext = {16'd0, w_shifted[15:0]};
            default: w_load_ext = w_shifted;
        endcase
    end

    // Completion pulse, fault flag and load result; load result holds between completions
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_done      <= 1'b0;
            o_fault     <= 1'b0;
            o_load_data <= 32'd0;
        end else begin
            o_done  <= 1'b0;
            o_fault <= 1'b0;
            if (w_accept && w_bad) begin
                o_done      <= 1'b1;
                o_fault     <= 1'b1;
                o_load_data <= 32'd0;
            end else if ((r_state == S_REQ) && i_mem_gnt && r_is_store) begin
                o_done <= 1'b1;
            end else if ((r_state == S_WAIT) && i_mem_rvalid) begin
                o_done      <= 1'b1;
                o_load_data <= w_load_ext;
            end
        end
    end

endmodule

// File: tb/tb_lsu.sv
// tb/tb_lsu.sv - directed self-checking bench for lsu
module tb_lsu;

    logic        clk;
    logic        rst_n;
    logic        i_request;
    logic        i_is_store;
    logic [2:0]  i_funct3;
    logic [31:0] i_address;
    logic [31:0] i_store_data;
    logic        o_busy;
    logic        o_done;
    logic        o_fault;
    logic [31:0] o_load_data;
    logic        o_mem_req;
    logic        o_mem_we;
    logic [31:0] o_mem_addr;
    logic [31:0] o_mem_wdata;
    logic [3:0]  o_mem_be;
    logic        i_mem_gnt;
    logic        i_mem_rvalid;
    logic [31:0] i_mem_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    lsu dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_request    (i_request),
        .i_is_store   (i_is_store),
        .i_funct3     (i_funct3),
        .i_address    (i_address),
        .i_store_data (i_store_data),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_fault      (o_fault),
        .o_load_data  (o_load_data),
        .o_mem_req    (o_mem_req),
        .o_mem_we     (o_mem_we),
        .o_mem_addr   (o_mem_addr),
        .o_mem_wdata  (o_mem_wdata),
        .o_mem_be     (o_mem_be),
        .i_mem_gnt    (i_mem_gnt),
        .i_mem_rvalid (i_mem_rvalid),
        .i_mem_rdata  (i_mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic set_req(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        i_request    = 1'b1;
        i_is_store   = st;
        i_funct3     = f3;
        i_address    = a;
        i_store_data = d;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; i_request = 0; i_is_store = 0; i_funct3 = 0; i_address = 0;
        i_store_data = 0; i_mem_gnt = 0; i_mem_rvalid = 0; i_mem_rdata = 0;
        tick(); tick();
        n_checks++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b want 0", o_busy); end
        n_checks++; if (o_done !== 1'b0 || o_fault !== 1'b0) begin n_fail++; $display("FAIL reset_done_fault: got %0b/%0b want 0/0", o_done, o_fault); end
        n_checks++; if (o_mem_req !== 1'b0 || o_mem_we !== 1'b0 || o_mem_be !== 4'h0) begin n_fail++; $display("FAIL reset_mem_ctl: got req=%0b we=%0b be=%b want 0/0/0000", o_mem_req, o_mem_we, o_mem_be); end
        n_checks++; if (o_mem_addr !== 32'd0 || o_mem_wdata !== 32'd0 || o_load_data !== 32'd0) begin n_fail++; $display("FAIL reset_data: got addr=%h wdata=%h ld=%h want 0", o_mem_addr, o_mem_wdata, o_load_data); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_sw();
        set_req(1'b1, 3'b010, 32'h100, 32'hDEADBEEF);
        i_mem_gnt = 1'b1;
        n_checks++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL sw_idle_busy: got %0b want 0", o_busy); end
        tick();
        i_request = 1'b0;
        n_checks++; if (o_mem_req !== 1'b1 || o_mem_we !== 1'b1 || o_mem_be !== 4'b1111) begin n_fail++; $display("FAIL sw_req: got req=%0b we=%0b be=%b want 1/1/1111", o_mem_req, o_mem_we, o_mem_be); end
        n_checks++; if (o_mem_addr !== 32'h100 || o_mem_wdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL sw_addr_data: got %h/%h want 00000100/deadbeef", o_mem_addr, o_mem_wdata); end
        n_checks++; if (o_busy !== 1'b1 || o_done !== 1'b0) begin n_fail++; $display("FAIL sw_busy: got busy=%0b done=%0b want 1/0", o_busy, o_done); end
        tick();
        n_checks++; if (o_done !== 1'b1 || o_fault !== 1'b0 || o_busy !== 1'b0) begin n_fail++; $display("FAIL sw_done: got done=%0b fault=%0b busy=%0b want 1/0/0", o_done, o_fault, o_busy); end
        n_checks++; if (o_mem_req !== 1'b0 || o_mem_we !== 1'b0 || o_mem_be !== 4'h0) begin n_fail++; $display("FAIL sw_mem_idle: got req=%0b we=%0b be=%b want 0/0/0000", o_mem_req, o_mem_we, o_mem_be); end
        tick();
        n_checks++; if (o_done !== 1'b0) begin n_fail++; $display("FAIL sw_done_pulse: got %0b want 0", o_done); end
    endtask

    task automatic run_load(input string nm, input logic [2:0] f3, input logic [31:0] a,
                            input logic [3:0] be_exp, input logic [31:0] rd, input logic [31:0] ld_exp);
        set_req(1'b0, f3, a, 32'h0);
        i_mem_gnt = 1'b1;
        tick();
        i_request = 1'b0;
        n_checks++; if (o_mem_req !== 1'b1 || o_mem_we !== 1'b0 || o_mem_be !== be_exp || o_mem_addr !== {a[31:2], 2'b00}) begin n_fail++; $display("FAIL %s_req: got req=%0b we=%0b be=%b addr=%h want 1/0/%b/%h", nm, o_mem_req, o_mem_we, o_mem_be, o_mem_addr, be_exp, {a[31:2], 2'b00}); end
        tick();
        n_checks++; if (o_mem_req !== 1'b0 || o_busy !== 1'b1 || o_done !== 1'b0) begin n_fail++; $display("FAIL %s_wait: got req=%0b busy=%0b done=%0b want 0/1/0", nm, o_mem_req, o_busy, o_done); end
        i_mem_rvalid = 1'b1; i_mem_rdata = rd;
        tick();
        i_mem_rvalid = 1'b0; i_mem_rdata = 32'h0;
        n_checks++; if (o_done !== 1'b1 || o_fault !== 1'b0 || o_load_data !== ld_exp || o_busy !== 1'b0) begin n_fail++; $display("FAIL %s_data: got done=%0b fault=%0b ld=%h busy=%0b want 1/0/%h/0", nm, o_done, o_fault, o_load_data, o_busy, ld_exp); end
        tick();
        n_checks++; if (o_done !== 1'b0 || o_load_data !== ld_exp) begin n_fail++; $display("FAIL %s_hold: got done=%0b ld=%h want 0/%h", nm, o_done, o_load_data, ld_exp); end
    endtask

    task automatic test_loads();
        run_load("lb",  3'b000, 32'h103, 4'b1000, 32'h80FF_FFFF, 32'hFFFF_FF80);
        run_load("lbu", 3'b100, 32'h103, 4'b1000, 32'h80FF_FFFF, 32'h0000_0080);
        run_load("lh",  3'b001, 32'h102, 4'b1100, 32'h9ABC_1234, 32'hFFFF_9ABC);
        run_load("lhu", 3'b101, 32'h102, 4'b1100, 32'h9ABC_1234, 32'h0000_9ABC);
        run_load("lw",  3'b010, 32'h300, 4'b1111, 32'hCAFE_F00D, 32'hCAFE_F00D);
    endtask

    task automatic test_sh_delayed_gnt();
        set_req(1'b1, 3'b001, 32'h202, 32'h0000_1234);
        i_mem_gnt = 1'b0;
        tick();
        // hold a competing request while busy; it must not disturb the access
        set_req(1'b0, 3'b010, 32'h999, 32'h5555_5555);
        for (int k = 0; k < 4; k++) begin
            if (k == 3) i_mem_gnt = 1'b1;
            n_checks++; if (o_mem_req !== 1'b1 || o_mem_we !== 1'b1 || o_mem_be !== 4'b1100 || o_busy !== 1'b1) begin n_fail++; $display("FAIL sh_hold_ctl%0d: got req=%0b we=%0b be=%b busy=%0b want 1/1/1100/1", k, o_mem_req, o_mem_we, o_mem_be, o_busy); end
            n_checks++; if (o_mem_addr !== 32'h200 || o_mem_wdata !== 32'h1234_1234 || o_done !== 1'b0) begin n_fail++; $display("FAIL sh_hold_data%0d: got addr=%h wdata=%h done=%0b want 00000200/12341234/0", k, o_mem_addr, o_mem_wdata, o_done); end
            tick();
        end
        i_request = 1'b0;
        n_checks++; if (o_done !== 1'b1 || o_fault !== 1'b0 || o_busy !== 1'b0) begin n_fail++; $display("FAIL sh_done: got done=%0b fault=%0b busy=%0b want 1/0/0", o_done, o_fault, o_busy); end
        tick();
        n_checks++; if (o_done !== 1'b0 || o_mem_req !== 1'b0) begin n_fail++; $display("FAIL sh_no_extra: got done=%0b req=%0b want 0/0", o_done, o_mem_req); end
    endtask

    task automatic run_fault(input string nm, input logic st, input logic [2:0] f3, input logic [31:0] a);
        set_req(st, f3, a, 32'h1111_2222);
        i_mem_gnt = 1'b1;
        tick();
        i_request = 1'b0;
        n_checks++; if (o_done !== 1'b1 || o_fault !== 1'b1 || o_load_data !== 32'd0) begin n_fail++; $display("FAIL %s_resp: got done=%0b fault=%0b ld=%h want 1/1/00000000", nm, o_done, o_fault, o_load_data); end
        n_checks++; if (o_mem_req !== 1'b0 || o_busy !== 1'b0) begin n_fail++; $display("FAIL %s_noaccess: got req=%0b busy=%0b want 0/0", nm, o_mem_req, o_busy); end
        tick();
        n_checks++; if (o_done !== 1'b0 || o_fault !== 1'b0 || o_mem_req !== 1'b0) begin n_fail++; $display("FAIL %s_pulse: got done=%0b fault=%0b req=%0b want 0/0/0", nm, o_done, o_fault, o_mem_req); end
    endtask

    task automatic test_fault();
        // load_data is nonzero from the previous LW, so zeroing is observable
        run_fault("lw_mis", 1'b0, 3'b010, 32'h101);
        run_load("lw2", 3'b010, 32'h104, 4'b1111, 32'h0BAD_CAFE, 32'h0BAD_CAFE);
        run_fault("f3_011", 1'b0, 3'b011, 32'h100);
        run_fault("lh_mis", 1'b0, 3'b101, 32'h103);
        run_fault("sbu_ill", 1'b1, 3'b100, 32'h100);
    endtask

    task automatic test_reset_in_wait();
        run_load("lw3", 3'b010, 32'h400, 4'b1111, 32'h1357_9BDF, 32'h1357_9BDF);
        set_req(1'b0, 3'b010, 32'h404, 32'h0);
        i_mem_gnt = 1'b1;
        tick();
        i_request = 1'b0;
        tick();
        n_checks++; if (o_busy !== 1'b1 || o_mem_req !== 1'b0) begin n_fail++; $display("FAIL rw_in_wait: got busy=%0b req=%0b want 1/0", o_busy, o_mem_req); end
        rst_n = 1'b0;
        #1;
        n_checks++; if (o_busy !== 1'b0 || o_load_data !== 32'd0 || o_mem_addr !== 32'd0 || o_done !== 1'b0) begin n_fail++; $display("FAIL rw_async: got busy=%0b ld=%h addr=%h done=%0b want 0/0/0/0", o_busy, o_load_data, o_mem_addr, o_done); end
        tick();
        rst_n = 1'b1;
        tick();
        i_mem_rvalid = 1'b1; i_mem_rdata = 32'hFFFF_FFFF;
        tick();
        i_mem_rvalid = 1'b0;
        n_checks++; if (o_done !== 1'b0 || o_load_data !== 32'd0 || o_busy !== 1'b0) begin n_fail++; $display("FAIL rw_ignore: got done=%0b ld=%h busy=%0b want 0/0/0", o_done, o_load_data, o_busy); end
        tick();
        n_checks++; if (o_done !== 1'b0 || o_mem_req !== 1'b0) begin n_fail++; $display("FAIL rw_quiet: got done=%0b req=%0b want 0/0", o_done, o_mem_req); end
    endtask

    task automatic test_back_to_back();
        set_req(1'b1, 3'b010, 32'h10, 32'hA5A5_0000);
        i_mem_gnt = 1'b1;
        tick();
        i_request = 1'b0;
        tick();
        n_checks++; if (o_done !== 1'b1 || o_busy !== 1'b0) begin n_fail++; $display("FAIL b2b_first_done: got done=%0b busy=%0b want 1/0", o_done, o_busy); end
        set_req(1'b1, 3'b000, 32'h13, 32'h0000_00AB);
        tick();
        i_request = 1'b0;
        n_checks++; if (o_mem_req !== 1'b1 || o_mem_be !== 4'b1000 || o_mem_wdata !== 32'hABAB_ABAB || o_mem_addr !== 32'h10) begin n_fail++; $display("FAIL b2b_second_req: got req=%0b be=%b wdata=%h addr=%h want 1/1000/abababab/00000010", o_mem_req, o_mem_be, o_mem_wdata, o_mem_addr); end
        n_checks++; if (o_done !== 1'b0) begin n_fail++; $display("FAIL b2b_gap: got done=%0b want 0", o_done); end
        tick();
        n_checks++; if (o_done !== 1'b1 || o_fault !== 1'b0) begin n_fail++; $display("FAIL b2b_second_done: got done=%0b fault=%0b want 1/0", o_done, o_fault); end
        tick();
    endtask

    initial begin
        test_reset();
        test_sw();
        test_loads();
        test_sh_delayed_gnt();
        test_fault();
        test_reset_in_wait();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 clk  input  1  Single clock; all state SHALL update on its rising edge.
REQ-002 rst_n  input  1  Reset, asynchronous assert, active-low; SHALL be the only reset.
REQ-003 Request  input  1  Execute stage presents a memory operation this cycle.
REQ-004 IsStore  input  1  1 = store, 0 = load.
REQ-005 Funct3  input  3  RV32I size/sign field: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-006 Address  input  32  Effective byte address, taken from the ALU result.
REQ-007 StoreData  input  32  rs2 value for stores.
REQ-008 Busy  output  1  Combinational; high while the FSM is not IDLE; stalls the execute stage.
REQ-009 Done  output  1  Registered one-cycle completion pulse.
REQ-010 Fault  output  1  Registered; high together with Done for a misaligned or illegal request.
REQ-011 LoadData  output  32  Registered, extended load result; valid when Done=1 and the operation is a load.
REQ-012 MemReq, MemWe  output  1 each  Data-memory request and write enable.
REQ-013 MemAddr  output  32  Word address with bits [1:0] = 00.
REQ-014 MemWdata  output  32  Lane-replicated store data.
REQ-015 MemBe  output  4  Byte enables.
REQ-016 MemGnt, MemRvalid  input  1 each  Request accepted; read data valid.
REQ-017 MemRdata  input  32  Read word.

Function
REQ-018 FSM states SHALL be IDLE, REQ and WAIT.
REQ-019 In IDLE, Request=1 SHALL be accepted; Request while Busy=1 SHALL be ignored.
REQ-020 Illegal requests are Funct3 011/110/111, or a store with Funct3[2]=1.
REQ-021 Misaligned requests are H/HU with Address[0]=1, or W with Address[1:0]≠00.
REQ-022 An illegal or misaligned request SHALL cause no memory access; the next cycle SHALL show Done=1, Fault=1, LoadData=0, and the FSM SHALL stay in IDLE.
REQ-023 A legal request SHALL register Address, data, Funct3 and IsStore, then enter REQ.
REQ-024 In REQ, MemReq SHALL be 1 with MemAddr, MemWe, MemBe and MemWdata stable until the cycle MemGnt=1.
REQ-025 Lane encoding, with off = Address[1:0]:
- B: MemBe = 0001<<off; MemWdata = {4{StoreData[7:0]}}.
- H: MemBe = 0011<<off; MemWdata = {2{StoreData[15:0]}}.
- W: MemBe = 1111; MemWdata = StoreData.
- Loads SHALL drive the same MemBe with MemWe=0.
REQ-026 Store granted in REQ SHALL set Done=1 on the next cycle and return to IDLE.
REQ-027 Load granted in REQ SHALL enter WAIT with MemReq=0.
REQ-028 In WAIT, MemRvalid=1 SHALL set Done=1 on the next cycle, with LoadData = (MemRdata >> 8*off) truncated to 8 or 16 bits and then extended: sign for B/H, zero for BU/HU; W passes through. The FSM then returns to IDLE.
REQ-029 MemRvalid outside WAIT SHALL be ignored.
REQ-030 Memory guarantees MemRvalid no earlier than the cycle after MemGnt.
REQ-031 Minimum latency from Request to Done SHALL be 2 cycles for a store and 3 cycles for a load.
REQ-032 Busy SHALL be 0 in the Done cycle, so a new Request MAY be accepted in that cycle.
REQ-033 Done and Fault SHALL be high for exactly one cycle per accepted request.
REQ-034 Outside Done cycles, LoadData SHALL hold its last value.
REQ-035 MemReq=0 SHALL hold MemWe=0 and MemBe=0000.

Reset
REQ-036 rst_n=0 SHALL immediately force state IDLE and drive to 0: MemReq, MemWe, MemBe, MemAddr, MemWdata, Done, Fault, LoadData.
REQ-037 Reset during REQ or WAIT SHALL abandon the access; a later MemRvalid SHALL be ignored.

Verification
REQ-038 SW: Address 0x100, StoreData 0xDEADBEEF, MemGnt held 1 -> MemReq=1 one cycle, MemAddr 0x100, MemBe 1111, MemWe=1, then Done at Request+2.
REQ-039 LB: Address 0x103, MemRdata 0x80FF_FFFF, Rvalid one cycle after Gnt -> LoadData 0xFFFFFF80; LBU on the same access -> 0x00000080; MemBe 1000.
REQ-040 SH: Address 0x202, StoreData 0x1234 -> MemBe 1100, MemWdata 0x12341234; MemGnt delayed 3 cycles -> MemReq and outputs held stable, Busy=1 throughout.
REQ-041 LW: Address 0x101 -> no MemReq; next cycle Done=1, Fault=1, LoadData 0. Funct3=011 -> same response.
REQ-042 rst_n low in WAIT, MemRvalid pulsed after release -> outputs 0, no Done pulse.
REQ-043 Back-to-back: new Request in a Done cycle is accepted, and MemReq rises the next cycle.
